// File: rtl/cascade_pkg.sv
// Shared constants, stage tables and FSM state type for the Haar cascade controller.
package cascade_pkg;

  localparam int unsigned FEATURE_NUM = 2913;
  localparam int unsigned STAGE_NUM   = 25;
  localparam int unsigned W_LEAF      = 14;
  localparam int unsigned W_ACC       = 22;
  localparam int unsigned W_STAGE_THR = 22;
  localparam int unsigned W_ADDR_FEAT = $clog2(FEATURE_NUM);
  localparam int unsigned W_STAGE     = $clog2(STAGE_NUM);
  // Receive counter shares the feature index width; covers any stage length.
  localparam int unsigned W_CNT       = W_ADDR_FEAT;

  // Exclusive end index of each stage; stage k covers [STAGE_END[k-1], STAGE_END[k]).
  localparam int unsigned STAGE_END [STAGE_NUM] = '{
    9, 25, 52, 84, 136, 189, 251, 323, 406, 497,
    596, 711, 838, 973, 1109, 1246, 1405, 1560, 1729, 1925,
    2122, 2303, 2502, 2713, 2913
  };

  // Signed stage thresholds in the same fixed-point scale as the leaf values.
  localparam int STAGE_THR [STAGE_NUM] = '{
    -5042, -5613, -4999, -4923, -4785, -4540, -4430, -4353, -4351, -4233,
    -4129, -4063, -3960, -3925, -3897, -3797, -3706, -3610, -3543, -3470,
    -3400, -3345, -3259, -3185, -3120
  };

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StDecide,
    StDone
  } state_e;

  // Index of the last feature of stage s.
  function automatic logic [W_ADDR_FEAT-1:0] stage_last_of(input logic [W_STAGE-1:0] s);
    int unsigned k;
    k = 32'(s);
    if (k >= STAGE_NUM) return '0;
    return W_ADDR_FEAT'(STAGE_END[k] - 1);
  endfunction

  // Number of features in stage s.
  function automatic logic [W_CNT-1:0] stage_len_of(input logic [W_STAGE-1:0] s);
    int unsigned k;
    int unsigned lo;
    k = 32'(s);
    if (k >= STAGE_NUM) return '0;
    lo = (k == 0) ? 0 : STAGE_END[k-1];
    return W_CNT'(STAGE_END[k] - lo);
  endfunction

  // Threshold of stage s at its native width.
  function automatic logic signed [W_STAGE_THR-1:0] stage_thr_of(input logic [W_STAGE-1:0] s);
    int unsigned k;
    k = 32'(s);
    if (k >= STAGE_NUM) return '0;
    return W_STAGE_THR'(STAGE_THR[k]);
  endfunction

endpackage

// File: rtl/stage_accum.sv
// Per-stage signed leaf accumulator with receive counter and threshold compare.
module stage_accum import cascade_pkg::*; (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          leaf_fire_i,
  input  logic signed [W_LEAF-1:0]      leaf_data_i,
  input  logic        [W_CNT-1:0]       stage_len_i,
  input  logic signed [W_STAGE_THR-1:0] thr_i,
  output logic                          stage_done_o,
  output logic                          stage_pass_o
);

  logic signed [W_ACC-1:0] acc_q, acc_d;
  logic        [W_CNT-1:0] cnt_q, cnt_d;
  logic signed [W_ACC-1:0] leaf_ext;
  logic signed [W_ACC-1:0] thr_ext;

  assign leaf_ext = {{(W_ACC - W_LEAF){leaf_data_i[W_LEAF-1]}}, leaf_data_i};
  assign thr_ext  = {{(W_ACC - W_STAGE_THR){thr_i[W_STAGE_THR-1]}}, thr_i};

  // Next accumulator/counter: clear has priority, otherwise add each accepted leaf.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (leaf_fire_i) begin
      acc_d = acc_q + leaf_ext;
      cnt_d = cnt_q + W_CNT'(1);
    end
  end

  // Accumulator and receive counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign stage_done_o = (cnt_q == stage_len_i);
  assign stage_pass_o = (acc_q >= thr_ext);

endmodule

// File: rtl/cascade_stage_ctrl.sv
// Haar cascade stage sequencer: issues feature indices per stage, accumulates leaves,
// decides pass/reject at each stage end and hands the verdict to the window scheduler.
module cascade_stage_ctrl import cascade_pkg::*; (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_valid_i,
  output logic                     start_ready_o,
  output logic                     feat_addr_valid_o,
  input  logic                     feat_addr_ready_i,
  output logic [W_ADDR_FEAT-1:0]   feat_addr_o,
  input  logic                     leaf_valid_i,
  output logic                     leaf_ready_o,
  input  logic signed [W_LEAF-1:0] leaf_data_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic                     result_pass_o,
  output logic [W_STAGE-1:0]       result_stage_o
);

  state_e state_q, state_d;
  logic [W_ADDR_FEAT-1:0] feat_addr_q, feat_addr_d;
  logic [W_STAGE-1:0]     stage_q, stage_d;
  logic                   result_pass_q, result_pass_d;
  logic [W_STAGE-1:0]     result_stage_q, result_stage_d;

  logic                          acc_clear;
  logic                          leaf_fire;
  logic                          stage_done;
  logic                          stage_pass;
  logic [W_CNT-1:0]              stage_len;
  logic [W_ADDR_FEAT-1:0]        stage_last;
  logic signed [W_STAGE_THR-1:0] stage_thr;

  assign stage_len  = stage_len_of(stage_q);
  assign stage_last = stage_last_of(stage_q);
  assign stage_thr  = stage_thr_of(stage_q);
  assign leaf_fire  = leaf_valid_i & leaf_ready_o;

  stage_accum u_stage_accum (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (acc_clear),
    .leaf_fire_i  (leaf_fire),
    .leaf_data_i  (leaf_data_i),
    .stage_len_i  (stage_len),
    .thr_i        (stage_thr),
    .stage_done_o (stage_done),
    .stage_pass_o (stage_pass)
  );

  // Next-state, issue pointer, result capture and handshake outputs.
  always_comb begin
    state_d           = state_q;
    feat_addr_d       = feat_addr_q;
    stage_d           = stage_q;
    result_pass_d     = result_pass_q;
    result_stage_d    = result_stage_q;
    start_ready_o     = 1'b0;
    feat_addr_valid_o = 1'b0;
    leaf_ready_o      = 1'b0;
    result_valid_o    = 1'b0;
    acc_clear         = 1'b0;

    unique case (state_q)
      StIdle: begin
        start_ready_o = 1'b1;
        if (start_valid_i) begin
          stage_d     = '0;
          feat_addr_d = '0;
          acc_clear   = 1'b1;
          state_d     = StIssue;
        end
      end

      StIssue: begin
        feat_addr_valid_o = 1'b1;
        leaf_ready_o      = 1'b1;
        if (feat_addr_ready_i) begin
          feat_addr_d = feat_addr_q + W_ADDR_FEAT'(1);
          if (feat_addr_q == stage_last) state_d = StWait;
        end
      end

      StWait: begin
        leaf_ready_o = 1'b1;
        if (stage_done) state_d = StDecide;
      end

      StDecide: begin
        result_stage_d = stage_q;
        if (stage_pass) begin
          if (stage_q == W_STAGE'(STAGE_NUM - 1)) begin
            result_pass_d = 1'b1;
            state_d       = StDone;
          end else begin
            // feat_addr_q already sits on the next stage's first feature.
            stage_d   = stage_q + W_STAGE'(1);
            acc_clear = 1'b1;
            state_d   = StIssue;
          end
        end else begin
          result_pass_d = 1'b0;
          state_d       = StDone;
        end
      end

      StDone: begin
        result_valid_o = 1'b1;
        if (result_ready_i) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      feat_addr_q    <= '0;
      stage_q        <= '0;
      result_pass_q  <= 1'b0;
      result_stage_q <= '0;
    end else begin
      state_q        <= state_d;
      feat_addr_q    <= feat_addr_d;
      stage_q        <= stage_d;
      result_pass_q  <= result_pass_d;
      result_stage_q <= result_stage_d;
    end
  end

  assign feat_addr_o    = feat_addr_q;
  assign result_pass_o  = result_pass_q;
  assign result_stage_o = result_stage_q;

  // A leaf offered while not accepting is a datapath protocol error; it is dropped.
  leaf_proto_a: assert property (@(posedge clk_i) disable iff (rst_i)
                                 !(leaf_valid_i && !leaf_ready_o));

endmodule

// File: tb/tb_cascade_stage_ctrl.sv
// Directed bench for cascade_stage_ctrl with a behavioural feature datapath and scoreboards.
module tb_cascade_stage_ctrl;
  import cascade_pkg::*;

  logic                     clk_i;
  logic                     rst_i;
  logic                     start_valid_i;
  logic                     start_ready_o;
  logic                     feat_addr_valid_o;
  logic                     feat_addr_ready_i;
  logic [W_ADDR_FEAT-1:0]   feat_addr_o;
  logic                     leaf_valid_i;
  logic                     leaf_ready_o;
  logic signed [W_LEAF-1:0] leaf_data_i;
  logic                     result_valid_o;
  logic                     result_ready_i;
  logic                     result_pass_o;
  logic [W_STAGE-1:0]       result_stage_o;

  cascade_stage_ctrl dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .start_valid_i     (start_valid_i),
    .start_ready_o     (start_ready_o),
    .feat_addr_valid_o (feat_addr_valid_o),
    .feat_addr_ready_i (feat_addr_ready_i),
    .feat_addr_o       (feat_addr_o),
    .leaf_valid_i      (leaf_valid_i),
    .leaf_ready_o      (leaf_ready_o),
    .leaf_data_i       (leaf_data_i),
    .result_valid_o    (result_valid_o),
    .result_ready_i    (result_ready_i),
    .result_pass_o     (result_pass_o),
    .result_stage_o    (result_stage_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    int pass;
    int stage;
  } res_t;

  int   total = 0;
  int   bad   = 0;
  int   leafv [FEATURE_NUM];
  int   exp_addr_q [$];
  res_t exp_res_q [$];
  int   pipe_addr [$];
  int   pipe_due [$];
  int   cyc;
  bit   stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Behavioural datapath: accepts indices (optionally stalling) and returns leaves in order
  // after 1..5 cycles; every accepted index is checked against the expected issue order.
  initial begin
    feat_addr_ready_i = 1'b0;
    leaf_valid_i      = 1'b0;
    leaf_data_i       = '0;
    cyc               = 0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (rst_i) begin
        pipe_addr.delete();
        pipe_due.delete();
        feat_addr_ready_i = 1'b0;
        leaf_valid_i      = 1'b0;
      end else begin
        feat_addr_ready_i = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (feat_addr_valid_o && feat_addr_ready_i) begin
          if (exp_addr_q.size() == 0) chk("feat_addr_extra", 32'(feat_addr_o), 32'hFFFF_FFFF);
          else chk("feat_addr", 32'(feat_addr_o), exp_addr_q.pop_front());
          pipe_addr.push_back(int'(feat_addr_o));
          pipe_due.push_back(cyc + (stall ? int'($urandom_range(1, 5)) : 1));
        end
        if (pipe_addr.size() > 0 && pipe_due[0] <= cyc && leaf_ready_o) begin
          leaf_valid_i = 1'b1;
          leaf_data_i  = W_LEAF'(leafv[pipe_addr.pop_front()]);
          void'(pipe_due.pop_front());
        end else begin
          leaf_valid_i = 1'b0;
        end
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_start_ready", 32'(start_ready_o), 1);
    chk("rst_feat_valid", 32'(feat_addr_valid_o), 0);
    chk("rst_feat_addr", 32'(feat_addr_o), 0);
    chk("rst_leaf_ready", 32'(leaf_ready_o), 0);
    chk("rst_result_valid", 32'(result_valid_o), 0);
    chk("rst_result_pass", 32'(result_pass_o), 0);
    chk("rst_result_stage", 32'(result_stage_o), 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    exp_addr_q.delete();
  endtask

  // Builds leaves so each stage sums exactly to its threshold, except fail_stage which
  // lands one below; fail_stage < 0 means every stage passes.
  task automatic launch(input int fail_stage, input bit st);
    int last_stage;
    int lo;
    int hi;
    int s;
    int v;
    stall      = st;
    last_stage = (fail_stage < 0) ? int'(STAGE_NUM) - 1 : fail_stage;
    for (int k = 0; k < int'(STAGE_NUM); k++) begin
      lo = (k == 0) ? 0 : int'(STAGE_END[k-1]);
      hi = int'(STAGE_END[k]);
      s  = 0;
      for (int i = lo; i < hi - 1; i++) begin
        v        = ((i * 7) % 21) - 10;
        leafv[i] = v;
        s        = s + v;
      end
      leafv[hi-1] = STAGE_THR[k] - ((k == fail_stage) ? 1 : 0) - s;
    end
    for (int i = 0; i < int'(STAGE_END[last_stage]); i++) exp_addr_q.push_back(i);
    exp_res_q.push_back('{pass: (fail_stage < 0) ? 1 : 0, stage: last_stage});
    chk("start_ready", 32'(start_ready_o), 1);
    start_valid_i = 1'b1;
    @(posedge clk_i); #2;
    start_valid_i = 1'b0;
  endtask

  // Waits for the verdict, checks it, optionally holds result_ready low, then releases.
  task automatic finish_window(input int hold, input int exp_lat);
    int   n;
    res_t e;
    n = 0;
    while (result_valid_o !== 1'b1 && n < 20000) begin
      @(posedge clk_i); #2;
      n++;
    end
    if (result_valid_o !== 1'b1) begin
      chk("result_timeout", 32'(result_valid_o), 1);
      exp_res_q.delete();
      do_reset();
      return;
    end
    if (exp_lat >= 0) chk("latency", 32'(n), 32'(exp_lat));
    e = exp_res_q.pop_front();
    chk("result_pass", 32'(result_pass_o), 32'(e.pass));
    chk("result_stage", 32'(result_stage_o), 32'(e.stage));
    chk("addr_all_issued", 32'(exp_addr_q.size()), 0);
    chk("leaves_drained", 32'(pipe_addr.size()), 0);
    for (int i = 0; i < hold; i++) begin
      start_valid_i = 1'b1;
      @(posedge clk_i); #2;
      chk("hold_valid", 32'(result_valid_o), 1);
      chk("hold_pass", 32'(result_pass_o), 32'(e.pass));
      chk("hold_stage", 32'(result_stage_o), 32'(e.stage));
      chk("hold_no_start", 32'(start_ready_o), 0);
      chk("hold_no_issue", 32'(feat_addr_valid_o), 0);
    end
    start_valid_i  = 1'b0;
    result_ready_i = 1'b1;
    @(posedge clk_i); #2;
    result_ready_i = 1'b0;
    chk("back_idle", 32'(start_ready_o), 1);
    chk("valid_drop", 32'(result_valid_o), 0);
    @(posedge clk_i); #2;
    chk("idle_no_issue", 32'(feat_addr_valid_o), 0);
  endtask

  initial begin
    int n;
    rst_i          = 1'b1;
    start_valid_i  = 1'b0;
    result_ready_i = 1'b0;
    stall          = 1'b0;
    repeat (2) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    check_reset_vals();

    // Stage 0 exactly at threshold passes; stage 1 one below rejects.
    launch(1, 1'b0);
    finish_window(0, -1);

    // Stage 0 one below threshold: reject at stage 0, 9-feature stage latency.
    launch(0, 1'b0);
    finish_window(0, 12);

    // Reject at stage 2 with stalls; consumer holds off 10 cycles while start is offered.
    launch(2, 1'b1);
    finish_window(10, -1);

    // Full cascade pass, no stalls, then the same with random stalls and latency.
    launch(-1, 1'b0);
    finish_window(0, -1);
    launch(-1, 1'b1);
    finish_window(0, -1);

    // Reset in the middle of stage 3, then a fresh window starting from index 0.
    launch(-1, 1'b0);
    n = 0;
    while (int'(feat_addr_o) < 60 && n < 1000) begin
      @(posedge clk_i); #2;
      n++;
    end
    chk("reached_stage3", 32'(int'(feat_addr_o) >= 60), 1);
    do_reset();
    exp_res_q.delete();
    check_reset_vals();
    launch(0, 1'b1);
    finish_window(0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
